// File: rtl/alu_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit: one operand bit per cycle,
// shift-add multiply and restoring divide, with sign fix-up on the final step.
module alu_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q;
    logic [CW-1:0]       count_q;
    logic                special_q;
    logic [2:0]          op_q;
    logic                neg_q;
    logic [XLEN-1:0]     a_q;
    logic [XLEN-1:0]     b_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [2*XLEN-1:0]   acc_d;
    logic [XLEN-1:0]     result_q;
    logic                out_valid_q;

    // Operand decode at accept: magnitudes, result sign and special divide cases
    logic            a_signed, b_signed, a_neg, b_neg, neg_d;
    logic [XLEN-1:0] a_mag, b_mag, special_res;
    logic            div_zero, div_ovf, is_special;

    always_comb begin
        a_signed    = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_signed    = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg       = a_signed & src_a[XLEN-1];
        b_neg       = b_signed & src_b[XLEN-1];
        a_mag       = a_neg ? (~src_a + 1'b1) : src_a;
        b_mag       = b_neg ? (~src_b + 1'b1) : src_b;
        // Remainder takes the dividend's sign; everything else the product of signs
        neg_d       = (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero    = op[2] && (src_b == '0);
        div_ovf     = op[2] && !op[0] && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
        is_special  = div_zero || div_ovf;
        special_res = '0;
        if (div_zero) begin
            special_res = op[1] ? src_a : '1;
        end else if (div_ovf) begin
            special_res = op[1] ? '0 : src_a;
        end
    end

    // One iteration step of either the multiplier or the divider, plus final fix-up
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_trial;
    logic              q_bit;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_val, mul_res, div_res, final_res;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_trial = div_shift - {1'b0, b_q};
        q_bit     = ~div_trial[XLEN];
        div_rem   = q_bit ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
        if (op_q[2]) begin
            acc_d = {div_rem, acc_q[XLEN-2:0], q_bit};
        end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
        prod_fix  = neg_q ? (~acc_d + 1'b1) : acc_d;
        mul_res   = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        div_val   = op_q[1] ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0];
        div_res   = neg_q ? (~div_val + 1'b1) : div_val;
        final_res = op_q[2] ? div_res : mul_res;
    end

    // Control FSM with registered result and out_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            special_q   <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q   <= CALC;
                        count_q   <= '0;
                        special_q <= is_special;
                        if (is_special) begin
                            result_q <= special_res;
                        end
                    end
                end
                CALC: begin
                    if (special_q) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        count_q <= count_q + 1'b1;
                        if (count_q == CW'(XLEN-1)) begin
                            result_q    <= final_res;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Datapath registers: loaded at accept, stepped once per CALC cycle
    always_ff @(posedge clk) begin
        if (state_q == IDLE && in_valid && !flush) begin
            op_q  <= op;
            neg_q <= neg_d;
            a_q   <= op[2] ? src_a : a_mag;
            b_q   <= op[2] ? b_mag : src_b;
            acc_q <= op[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
            if (op == 3'b000) begin
                acc_q <= {{XLEN{1'b0}}, src_b};
            end
        end else if (state_q == CALC && !special_q) begin
            acc_q <= acc_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv at XLEN = 32: directed test-plan cases,
// randomized operations, backpressure, flush and asynchronous reset.
module tb_alu_muldiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    alu_muldiv #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .src_a(src_a), .src_b(src_b), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference results from the RISC-V M-extension rules using 64-bit arithmetic
    function automatic logic [31:0] ref_f(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        longint p;
        logic [31:0] r;
        case (o)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: begin
                if (b == 0) r = 32'hFFFFFFFF;
                else begin p = ua / ub; r = p[31:0]; end
            end
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'd0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: begin
                if (b == 0) r = a;
                else begin p = ua % ub; r = p[31:0]; end
            end
        endcase
        return r;
    endfunction

    function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        return o[2] && ((b == 0) || ((o == 3'd4 || o == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF));
    endfunction

    // Timing model: 0 idle, 1 busy (counting down to result), 2 result held
    int          m_phase;
    int          m_wait;
    logic        m_valid;
    logic [31:0] m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_valid <= 1'b0;
            m_res   <= '0;
            m_wait  <= 0;
        end else if (flush) begin
            m_phase <= 0;
            m_valid <= 1'b0;
        end else if (m_phase == 0) begin
            if (in_valid) begin
                m_phase <= 1;
                m_res   <= ref_f(op, src_a, src_b);
                m_wait  <= is_special(op, src_a, src_b) ? 1 : 32;
            end
        end else if (m_phase == 1) begin
            if (m_wait == 1) begin
                m_phase <= 2;
                m_valid <= 1'b1;
            end
            m_wait <= m_wait - 1;
        end else if (out_ready) begin
            m_phase <= 0;
            m_valid <= 1'b0;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_in_ready", {31'b0, in_ready}, {31'b0, m_phase == 0});
            chk("cyc_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
            if (m_valid) chk("cyc_result", result, m_res);
        end
    end

    // Issue one op, measure latency, hold the result for 'hold' cycles, then take it
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input string name, input int hold);
        int w;
        int lat;
        bit got;
        @(negedge clk);
        in_valid = 1'b1; op = o; src_a = a; src_b = b; out_ready = 1'b0;
        w = 0;
        while (!in_ready && w < 200) begin @(negedge clk); w++; end
        if (w >= 200) chk({name, "_accept_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        lat = 0; got = 0;
        while (lat < 100 && !got) begin
            @(negedge clk);
            in_valid = 1'($urandom); op = 3'($urandom); src_a = $urandom; src_b = $urandom;
            @(posedge clk);
            lat++;
            #1 got = out_valid;
        end
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_result"}, result, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1; op = 3'($urandom); src_a = $urandom; src_b = $urandom;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 chk({name, "_drop"}, {30'b0, out_valid, in_ready}, 32'b01);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        logic [2:0]  o;
        logic [31:0] a, b;
        int mode;

        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_result", result, 32'd0);
        #12 rst_n = 1'b1;

        // Pin the model with hand-computed values
        chk("pin_mulh", ref_f(3'd1, 32'h80000000, 32'h80000000), 32'h40000000);
        chk("pin_rem", ref_f(3'd6, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);
        chk("pin_mulhsu", ref_f(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);

        run_op(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 32, "mul", 0);
        run_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32, "mulh", 0);
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, "mulhsu", 0);
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32, "mulhu", 10);
        run_op(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32, "div", 0);
        run_op(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32, "rem", 0);
        run_op(3'd5, 32'd100, 32'd7, 32'd14, 32, "divu", 0);
        run_op(3'd7, 32'd100, 32'd7, 32'd2, 32, "remu", 0);
        run_op(3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, 1, "div0", 0);
        run_op(3'd7, 32'd5, 32'd0, 32'd5, 1, "remu0", 0);
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "divovf", 0);
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, "removf", 3);

        // Flush in IDLE blocks the accept
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; op = 3'd5; src_a = 32'd9; src_b = 32'd3;
        @(posedge clk);
        #1 chk("flush_idle_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;

        // Flush at CALC count 10
        @(negedge clk);
        in_valid = 1'b1; op = 3'd5; src_a = 32'd12345; src_b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 chk("flush_calc_ready", {30'b0, out_valid, in_ready}, 32'b01);
        @(negedge clk);
        flush = 1'b0;
        repeat (40) @(negedge clk);
        run_op(3'd5, 32'd100, 32'd7, 32'd14, 32, "divu_after_flush", 0);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        in_valid = 1'b1; op = 3'd1; src_a = 32'h12345678; src_b = 32'h9ABCDEF0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", {30'b0, out_valid, in_ready}, 32'b01);
        chk("async_rst_result", result, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        run_op(3'd5, 32'd100, 32'd7, 32'd14, 32, "divu_after_rst", 0);

        // Randomized operations with special cases mixed in
        for (int n = 0; n < 48; n++) begin
            o = 3'($urandom);
            a = $urandom;
            b = $urandom;
            mode = $urandom_range(0, 7);
            if (mode == 0) b = 32'd0;
            else if (mode == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            else if (mode == 2) begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
            else if (mode == 3) b = 32'hFFFFFFFF - $urandom_range(0, 5);
            run_op(o, a, b, ref_f(o, a, b), is_special(o, a, b) ? 1 : 32, "rand", $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
